// File: rtl/mem_arbiter.sv
// Two-way I-cache / D-cache arbiter in front of a single cacheline memory port.
// Optional build macro: ARB_ROUND_ROBIN_EN (round-robin tie-break; default is fixed D priority).
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_mem_read,
    input  logic [ADDR_WIDTH-1:0] i_mem_address,
    output logic [LINE_WIDTH-1:0] i_mem_rdata,
    output logic                  i_mem_resp,
    input  logic                  d_mem_read,
    input  logic                  d_mem_write,
    input  logic [ADDR_WIDTH-1:0] d_mem_address,
    input  logic [LINE_WIDTH-1:0] d_mem_wdata,
    output logic [LINE_WIDTH-1:0] d_mem_rdata,
    output logic                  d_mem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic                  arb_busy,
    output logic [1:0]            dbg_state
);

    // Handshake: a requester raises read/write with stable address/data and holds it
    // until its resp pulses for exactly one cycle; resp is pmem_resp routed to the owner.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t state, state_next;
    logic   last_d, last_d_next;
    logic   i_pend, d_pend, grant_d;

    assign i_pend = i_mem_read;
    assign d_pend = d_mem_read | d_mem_write;

`ifdef ARB_ROUND_ROBIN_EN
    assign grant_d = d_pend & (~i_pend | ~last_d);
`else
    assign grant_d = d_pend;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            state  <= state_next;
            last_d <= last_d_next;
        end
    end

    always_comb begin
        state_next  = state;
        last_d_next = last_d;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_next  = SERVE_D;
                    last_d_next = 1'b1;
                end else if (i_pend) begin
                    state_next  = SERVE_I;
                    last_d_next = 1'b0;
                end
            end
            // The grant always returns through IDLE so a just-served request is dropped first.
            SERVE_I, SERVE_D: begin
                if (pmem_resp) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_mem_resp   = 1'b0;
        d_mem_resp   = 1'b0;
        case (state)
            SERVE_I: begin
                pmem_read    = i_mem_read;
                pmem_address = i_mem_address;
                i_mem_resp   = pmem_resp;
            end
            SERVE_D: begin
                // A simultaneous read+write from the D side is issued as the writeback.
                pmem_write   = d_mem_write;
                pmem_read    = d_mem_read & ~d_mem_write;
                pmem_address = d_mem_address;
                pmem_wdata   = d_mem_wdata;
                d_mem_resp   = pmem_resp;
            end
            default: ;
        endcase
    end

    assign i_mem_rdata = pmem_rdata;
    assign d_mem_rdata = pmem_rdata;
    assign arb_busy    = (state != IDLE);
    assign dbg_state   = state;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-way memory arbiter sharing one physical-memory (cacheline) port between the instruction-cache miss path and the data-cache miss/writeback path of the pipelined RV32I core. Sits between the two caches and the cacheline adaptor. A three-state FSM grants one requester at a time, forwards its request downstream, and routes the single-cycle response back. Grant is held until that response.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width.
- LINE_WIDTH, 256, cacheline data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- i_mem_read  in  1  I-side line read request; held until i_mem_resp.
- i_mem_address  in  ADDR_WIDTH  I-side line address; stable while request held.
- i_mem_rdata  out  LINE_WIDTH  I-side read data; valid when i_mem_resp=1.
- i_mem_resp  out  1  I-side completion pulse, 1 cycle.
- d_mem_read  in  1  D-side line read request.
- d_mem_write  in  1  D-side line write (writeback) request.
- d_mem_address  in  ADDR_WIDTH  D-side line address.
- d_mem_wdata  in  LINE_WIDTH  D-side write data.
- d_mem_rdata  out  LINE_WIDTH  D-side read data; valid when d_mem_resp=1.
- d_mem_resp  out  1  D-side completion pulse, 1 cycle.
- pmem_read  out  1  downstream read request.
- pmem_write  out  1  downstream write request.
- pmem_address  out  ADDR_WIDTH  downstream address.
- pmem_wdata  out  LINE_WIDTH  downstream write data.
- pmem_rdata  in  LINE_WIDTH  downstream read data.
- pmem_resp  in  1  downstream completion pulse.
- arb_busy  out  1  1 when state is not IDLE.

## Operation
- States: IDLE, SERVE_I, SERVE_D. Reset state is IDLE.
- Transitions from IDLE:
  - Only I pending: go to SERVE_I.
  - Only D pending: go to SERVE_D.
  - Both pending: priority rule (see Configuration).
  - Neither pending: stay in IDLE.
- "D pending" means d_mem_read or d_mem_write.
- SERVE_x:
  - pmem_read, pmem_write, pmem_address and pmem_wdata are driven combinationally from requester x.
  - For I, pmem_write=0 and pmem_wdata=0.
  - When pmem_resp=1, x_mem_resp=1 in the same cycle, and the next state is IDLE.
- If requester x deasserts its request before the response arrives, that is a protocol violation. The FSM still waits for pmem_resp.
- d_mem_read and d_mem_write both 1 is treated as a write: pmem_write=1, pmem_read=0.
- i_mem_rdata and d_mem_rdata are always driven with pmem_rdata. Consumers qualify the data with their resp signal.
- In IDLE, all pmem_* outputs are 0.
- The resp output for the requester that is not granted is always 0.
- pmem_resp arriving in IDLE is ignored and produces no upstream resp.
- A round-robin pointer last_d (1 bit) records the last granted side. It updates on every grant.

## Timing
- Reset, asynchronous and immediate: state=IDLE, last_d=0, and all outputs 0 (pmem_*, i_/d_mem_resp, arb_busy, rdata 0 if pmem_rdata=0). Reset asserted mid-transfer abandons the transfer with no resp. The downstream is reset with the arbiter.
- Grant latency: a request seen in IDLE at edge N produces a pmem request in the cycle after edge N.
- Response: upstream resp has zero added latency (combinational pass-through of pmem_resp).
- Recovery: the cycle after a resp is always IDLE, a one-cycle dead slot. It lets the requester drop its request, so a stale request is never re-granted.
- Back-to-back: if the resp arrives in cycle M, the next downstream request is issued in cycle M+2.
- Both ports pending continuously: grants follow the priority rule with no starvation in round-robin mode.

## Configuration
- ARB_ROUND_ROBIN_EN defined: simultaneous I/D pending grants the side opposite last_d. After reset (last_d=0), D is granted first.
- ARB_ROUND_ROBIN_EN undefined: fixed priority; D always wins simultaneous requests. last_d is still maintained, but it does not affect grants.

## Test plan
- Reset mid-SERVE_D with pmem_write=1: drive rst=0 asynchronously -> pmem_write=0, arb_busy=0 before the next edge; after release, state is IDLE and d_mem_resp is never pulsed.
- Lone I read to 0x0000_0060, pmem_resp after 3 cycles with rdata=0xA5..A5 -> pmem_read=1 and pmem_address=0x60 from cycle 1; i_mem_resp=1 with i_mem_rdata=0xA5..A5 in the same cycle as pmem_resp; d_mem_resp=0 throughout.
- D writeback to 0x1000_0000 with wdata=0x1234..: pmem_write=1, pmem_read=0, and pmem_wdata matches until pmem_resp; then arb_busy=0 for one cycle.
- I and D both held high for 4 transactions, memory latency 2, round-robin build -> grant order D, I, D, I; downstream requests separated by exactly one IDLE cycle.
- Same stimulus in fixed-priority build, with D dropping its request after 2 transactions -> grant order D, D, I, I.
- Stray pmem_resp in IDLE, and d_mem_read plus d_mem_write both 1 -> no upstream resp for the stray pulse; the dual request issues pmem_write=1 only.
